gpa_fhdo_dac_model: RTL and testbench

Synthesisable SPI responder that emulates the DAC80504 four-channel DAC on the GPA-FHDO board: the receiving end of the gradient-interface SPI link. It oversamples SCLK/CSn/MOSI in the system clock domain, decodes 24-bit write frames into a SYNC register and four DAC channel registers, and answers read-back frames on MISO. It sits on-chip as a loopback target, replacing the physical board for hardware-in-loop tests and simulation of the gradient path.

---
 rtl/gpa_fhdo_dac_model.sv | 241 ++++++++++++++++++++++++
 tb/tb_gpa_fhdo_dac_model.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpa_fhdo_dac_model.sv
// gpa_fhdo_dac_model
// On-chip stand-in for the DAC80504 on the GPA-FHDO gradient board.
// Oversamples the SPI pins in the clk domain, decodes 24-bit frames into the
// SYNC register and four DAC channel registers, and returns read-back data
// on MISO during the frame that follows a read command.
//
// Frame layout (MSB first): [23] R/nW, [22:20] don't care, [19:16] address,
// [15:0] data. SCLK idles high. The master changes MOSI while SCLK is high,
// so MOSI is captured on SCLK falling edges and MISO is driven on SCLK
// rising edges.
//
// Status strobes: update_o and frame_err_o are single-cycle pulses with no
// handshake. update_o and the new register values appear on the same clk.

module gpa_fhdo_dac_model #(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [15:0] SYNC_RST_VAL = 16'hFF00,
  parameter logic [15:0] DAC_RST_VAL  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fhd_clk_i,
  input  logic        fhd_sdo_i,
  input  logic        fhd_csn_i,
  output logic        fhd_sdi_o,
  output logic [15:0] sync_reg_o,
  output logic [15:0] dac0_o,
  output logic [15:0] dac1_o,
  output logic [15:0] dac2_o,
  output logic [15:0] dac3_o,
  output logic        update_o,
  output logic [3:0]  update_addr_o,
  output logic        frame_err_o,
  output logic [15:0] frame_cnt_o
);

  // A synchroniser shorter than two flops is not meaningful; clamp it.
  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [3:0] ADDR_SYNC = 4'd2;
  localparam logic [3:0] ADDR_DAC0 = 4'd8;
  localparam logic [3:0] ADDR_DAC1 = 4'd9;
  localparam logic [3:0] ADDR_DAC2 = 4'd10;
  localparam logic [3:0] ADDR_DAC3 = 4'd11;

  localparam logic [4:0] FRAME_BITS = 5'd24;
  localparam logic [4:0] CNT_MAX    = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_WAIT_CS = 2'd2
  } state_t;

  // Synchroniser chains and the extra edge-detect stage
  logic [NS-1:0] r_sclk_sync;
  logic [NS-1:0] r_csn_sync;
  logic [NS-1:0] r_mosi_sync;
  logic          r_sclk_d;
  logic          r_csn_d;

  // Frame state
  state_t        r_state;
  logic [23:0]   r_rx;
  logic [23:0]   r_tx;
  logic [4:0]    r_bit_cnt;
  logic          r_rd_pending;
  logic [23:0]   r_rd_word;

  // Register file and status outputs
  logic [15:0]   r_sync_reg;
  logic [15:0]   r_dac0;
  logic [15:0]   r_dac1;
  logic [15:0]   r_dac2;
  logic [15:0]   r_dac3;
  logic          r_update;
  logic [3:0]    r_update_addr;
  logic          r_frame_err;
  logic [15:0]   r_frame_cnt;
  logic          r_sdi;

  // Synchronised pin levels and edges
  logic          w_sclk;
  logic          w_csn;
  logic          w_mosi;
  logic          w_sclk_fall;
  logic          w_sclk_rise;
  logic          w_csn_fall;
  logic          w_csn_rise;

  // Shift state including any SCLK falling edge seen this cycle
  logic [23:0]   w_rx_next;
  logic [4:0]    w_cnt_next;
  logic [3:0]    w_addr;
  logic [15:0]   w_rd_data;

  // Pin synchronisers; left running through reset so the pin levels are
  // already valid when reset releases (needed to spot a frame in progress).
  always_ff @(posedge clk) begin
    r_sclk_sync <= {r_sclk_sync[NS-2:0], fhd_clk_i};
    r_csn_sync  <= {r_csn_sync[NS-2:0], fhd_csn_i};
    r_mosi_sync <= {r_mosi_sync[NS-2:0], fhd_sdo_i};
    r_sclk_d    <= r_sclk_sync[NS-1];
    r_csn_d     <= r_csn_sync[NS-1];
  end

  assign w_sclk      = r_sclk_sync[NS-1];
  assign w_csn       = r_csn_sync[NS-1];
  assign w_mosi      = r_mosi_sync[NS-1];
  assign w_sclk_fall = r_sclk_d & ~w_sclk;
  assign w_sclk_rise = ~r_sclk_d & w_sclk;
  assign w_csn_fall  = r_csn_d & ~w_csn;
  assign w_csn_rise  = ~r_csn_d & w_csn;

  // Fold a same-cycle SCLK falling edge into the shifter before the frame
  // is judged, so a bit coinciding with CSn rising is still counted.
  always_comb begin
    w_rx_next  = r_rx;
    w_cnt_next = r_bit_cnt;
    if (w_sclk_fall) begin
      w_rx_next = {r_rx[22:0], w_mosi};
      if (r_bit_cnt != CNT_MAX) begin
        w_cnt_next = r_bit_cnt + 5'd1;
      end
    end
  end

  assign w_addr = w_rx_next[19:16];

  // Read-back mux; unmapped addresses read as zero
  always_comb begin
    w_rd_data = 16'h0000;
    case (w_addr)
      ADDR_SYNC: w_rd_data = r_sync_reg;
      ADDR_DAC0: w_rd_data = r_dac0;
      ADDR_DAC1: w_rd_data = r_dac1;
      ADDR_DAC2: w_rd_data = r_dac2;
      ADDR_DAC3: w_rd_data = r_dac3;
      default:   w_rd_data = 16'h0000;
    endcase
  end

  // Frame FSM, shifters, register file and status strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_rx          <= 24'h000000;
      r_tx          <= 24'h000000;
      r_bit_cnt     <= 5'd0;
      r_rd_pending  <= 1'b0;
      r_rd_word     <= 24'h000000;
      r_sync_reg    <= SYNC_RST_VAL;
      r_dac0        <= DAC_RST_VAL;
      r_dac1        <= DAC_RST_VAL;
      r_dac2        <= DAC_RST_VAL;
      r_dac3        <= DAC_RST_VAL;
      r_update      <= 1'b0;
      r_update_addr <= 4'h0;
      r_frame_err   <= 1'b0;
      r_frame_cnt   <= 16'h0000;
      r_sdi         <= 1'b0;
    end else begin
      r_update    <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sdi <= 1'b0;
          if (w_csn_fall) begin
            r_state      <= ST_SHIFT;
            r_bit_cnt    <= 5'd0;
            r_rx         <= 24'h000000;
            r_tx         <= r_rd_pending ? r_rd_word : 24'h000000;
            r_rd_pending <= 1'b0;
          end else if (!w_csn) begin
            // CSn low without a seen falling edge: a frame that started
            // before reset released. Sit it out.
            r_state <= ST_WAIT_CS;
          end
        end

        ST_SHIFT: begin
          if (w_csn_rise) begin
            r_state <= ST_IDLE;
            r_sdi   <= 1'b0;
            if (w_cnt_next == FRAME_BITS) begin
              r_frame_cnt <= r_frame_cnt + 16'd1;
              if (!w_rx_next[23]) begin
                r_update      <= 1'b1;
                r_update_addr <= w_addr;
                case (w_addr)
                  ADDR_SYNC: r_sync_reg <= w_rx_next[15:0];
                  ADDR_DAC0: r_dac0     <= w_rx_next[15:0];
                  ADDR_DAC1: r_dac1     <= w_rx_next[15:0];
                  ADDR_DAC2: r_dac2     <= w_rx_next[15:0];
                  ADDR_DAC3: r_dac3     <= w_rx_next[15:0];
                  default: ;
                endcase
              end else begin
                r_rd_word    <= {8'h00, w_rd_data};
                r_rd_pending <= 1'b1;
              end
            end else begin
              r_frame_err  <= 1'b1;
              r_rd_pending <= 1'b0;
            end
          end else begin
            r_rx      <= w_rx_next;
            r_bit_cnt <= w_cnt_next;
            if (w_sclk_rise) begin
              r_sdi <= r_tx[23];
              r_tx  <= {r_tx[22:0], 1'b0};
            end
          end
        end

        ST_WAIT_CS: begin
          r_sdi <= 1'b0;
          if (w_csn) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fhd_sdi_o     = r_sdi;
  assign sync_reg_o    = r_sync_reg;
  assign dac0_o        = r_dac0;
  assign dac1_o        = r_dac1;
  assign dac2_o        = r_dac2;
  assign dac3_o        = r_dac3;
  assign update_o      = r_update;
  assign update_addr_o = r_update_addr;
  assign frame_err_o   = r_frame_err;
  assign frame_cnt_o   = r_frame_cnt;

endmodule

// File: tb/tb_gpa_fhdo_dac_model.sv
// tb_gpa_fhdo_dac_model
// Directed bench acting as the SPI master at SCLK = clk/8. Expected update
// addresses and expected MISO words are queued as frames are driven and
// popped when the DUT produces them.

module tb_gpa_fhdo_dac_model;

  logic        clk;
  logic        rst;
  logic        fhd_clk_i;
  logic        fhd_sdo_i;
  logic        fhd_csn_i;
  logic        fhd_sdi_o;
  logic [15:0] sync_reg_o;
  logic [15:0] dac0_o;
  logic [15:0] dac1_o;
  logic [15:0] dac2_o;
  logic [15:0] dac3_o;
  logic        update_o;
  logic [3:0]  update_addr_o;
  logic        frame_err_o;
  logic [15:0] frame_cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;

  logic [3:0]  exp_q[$];
  logic [23:0] miso_q[$];
  logic [23:0] miso_word;

  gpa_fhdo_dac_model #(
    .SYNC_STAGES (2),
    .SYNC_RST_VAL(16'hFF00),
    .DAC_RST_VAL (16'h0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fhd_clk_i    (fhd_clk_i),
    .fhd_sdo_i    (fhd_sdo_i),
    .fhd_csn_i    (fhd_csn_i),
    .fhd_sdi_o    (fhd_sdi_o),
    .sync_reg_o   (sync_reg_o),
    .dac0_o       (dac0_o),
    .dac1_o       (dac1_o),
    .dac2_o       (dac2_o),
    .dac3_o       (dac3_o),
    .update_o     (update_o),
    .update_addr_o(update_addr_o),
    .frame_err_o  (frame_err_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Update strobe monitor: pops the expected address queue
  always @(negedge clk) begin
    if (!rst && update_o === 1'b1) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_errors++;
        $error("FAIL update_unexpected: observed addr=%h expected no update", update_addr_o);
      end
      if (exp_q.size() > 0) chk("update_addr", {28'd0, update_addr_o}, {28'd0, exp_q.pop_front()});
    end
  end

  // Frame error strobe counter
  always @(negedge clk) begin
    if (!rst && frame_err_o === 1'b1) err_seen++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk);
    fhd_csn_i = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    fhd_csn_i = 1'b1;
    wait_clk(10);
  endtask

  // Shift nbits of data MSB first; MISO is sampled late in each high phase
  task automatic spi_bits(input logic [31:0] data, input int nbits, output logic [23:0] miso);
    miso = 24'h000000;
    for (int i = 0; i < nbits; i++) begin
      fhd_sdo_i = data[nbits-1-i];
      wait_clk(4);
      if (i > 0) miso = {miso[22:0], fhd_sdi_o};
      fhd_clk_i = 1'b0;
      wait_clk(4);
      fhd_clk_i = 1'b1;
    end
    wait_clk(4);
    if (nbits > 0) miso = {miso[22:0], fhd_sdi_o};
  endtask

  task automatic spi_frame(input logic [31:0] data, input int nbits, output logic [23:0] miso);
    cs_low();
    spi_bits(data, nbits, miso);
    cs_high();
  endtask

  initial begin
    rst       = 1'b1;
    fhd_clk_i = 1'b1;
    fhd_csn_i = 1'b1;
    fhd_sdo_i = 1'b0;
    wait_clk(10);
    rst = 1'b0;
    wait_clk(4);

    // Reset state
    chk("rst_sync", {16'd0, sync_reg_o}, 32'h0000FF00);
    chk("rst_dac0", {16'd0, dac0_o}, 32'h0);
    chk("rst_dac1", {16'd0, dac1_o}, 32'h0);
    chk("rst_dac2", {16'd0, dac2_o}, 32'h0);
    chk("rst_dac3", {16'd0, dac3_o}, 32'h0);
    chk("rst_cnt", {16'd0, frame_cnt_o}, 32'h0);
    chk("rst_sdi", {31'd0, fhd_sdi_o}, 32'h0);
    chk("rst_upd_addr", {28'd0, update_addr_o}, 32'h0);

    // Two writes: SYNC then DAC1
    exp_q.push_back(4'h2);
    spi_frame(32'h020000, 24, miso_word);
    exp_q.push_back(4'h9);
    spi_frame(32'h091234, 24, miso_word);
    chk("wr_sync", {16'd0, sync_reg_o}, 32'h0);
    chk("wr_dac1", {16'd0, dac1_o}, 32'h1234);
    chk("wr_cnt", {16'd0, frame_cnt_o}, 32'd2);
    chk("wr_upd_q", exp_q.size(), 32'd0);

    // Write DAC2, read it back, shift the word out on the next frame
    exp_q.push_back(4'hA);
    spi_frame(32'h0ABEEF, 24, miso_word);
    chk("wr_dac2", {16'd0, dac2_o}, 32'hBEEF);
    miso_q.push_back(24'h000000);
    spi_frame(32'h8A0000, 24, miso_word);
    chk("miso_no_pending", {8'd0, miso_word}, {8'd0, miso_q.pop_front()});
    miso_q.push_back(24'h00BEEF);
    spi_frame(32'h8F0000, 24, miso_word);
    chk("miso_readback", {8'd0, miso_word}, {8'd0, miso_q.pop_front()});
    chk("rd_dac2_kept", {16'd0, dac2_o}, 32'hBEEF);
    chk("rd_cnt", {16'd0, frame_cnt_o}, 32'd5);
    exp_q.push_back(4'hB);
    miso_q.push_back(24'h000000);
    spi_frame(32'h0B5555, 24, miso_word);
    chk("miso_unmapped", {8'd0, miso_word}, {8'd0, miso_q.pop_front()});
    chk("wr_dac3", {16'd0, dac3_o}, 32'h5555);
    chk("cnt_6", {16'd0, frame_cnt_o}, 32'd6);

    // Short, long and empty frames
    spi_frame(32'h09FFFF, 23, miso_word);
    chk("err_23", err_seen, 32'd1);
    spi_frame(32'h009FFFF, 25, miso_word);
    chk("err_25", err_seen, 32'd2);
    spi_frame(32'h0, 0, miso_word);
    chk("err_0", err_seen, 32'd3);
    chk("err_dac1", {16'd0, dac1_o}, 32'h1234);
    chk("err_sync", {16'd0, sync_reg_o}, 32'h0);
    chk("err_cnt", {16'd0, frame_cnt_o}, 32'd6);

    // Unmapped write address
    exp_q.push_back(4'hF);
    spi_frame(32'h0FABCD, 24, miso_word);
    chk("unmap_addr", {28'd0, update_addr_o}, 32'hF);
    chk("unmap_cnt", {16'd0, frame_cnt_o}, 32'd7);
    chk("unmap_dac0", {16'd0, dac0_o}, 32'h0);
    chk("unmap_dac1", {16'd0, dac1_o}, 32'h1234);
    chk("unmap_dac2", {16'd0, dac2_o}, 32'hBEEF);
    chk("unmap_dac3", {16'd0, dac3_o}, 32'h5555);
    chk("unmap_sync", {16'd0, sync_reg_o}, 32'h0);

    // Reset in the middle of a frame; the remainder must be ignored
    cs_low();
    spi_bits(32'h000800, 12, miso_word);
    @(negedge clk);
    rst = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    spi_bits(32'h0000AA, 12, miso_word);
    cs_high();
    chk("mid_rst_dac0", {16'd0, dac0_o}, 32'h0);
    chk("mid_rst_sync", {16'd0, sync_reg_o}, 32'h0000FF00);
    chk("mid_rst_cnt", {16'd0, frame_cnt_o}, 32'h0);
    chk("mid_rst_err", err_seen, 32'd3);
    exp_q.push_back(4'h8);
    spi_frame(32'h0800FF, 24, miso_word);
    chk("post_rst_dac0", {16'd0, dac0_o}, 32'h00FF);
    chk("post_rst_cnt", {16'd0, frame_cnt_o}, 32'd1);
    chk("post_rst_dac1", {16'd0, dac1_o}, 32'h0);

    wait_clk(10);
    chk("upd_q_empty", exp_q.size(), 32'd0);
    chk("miso_q_empty", miso_q.size(), 32'd0);
    chk("err_total", err_seen, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
